// File: rtl/imm_pkg.sv
// Shared definitions for the ID-stage immediate unit: format encodings and
// the supported datapath widths.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_ZERO  = 3'b110,
        IMM_ZIMM  = 3'b111
    } imm_ctrl_e;

    localparam int IMM_XLEN_32 = 32;
    localparam int IMM_XLEN_64 = 64;

endpackage

// File: rtl/imm_format.sv
// Combinational immediate formatter: extracts the immediate selected by
// imm_ctrl_ID from a 32-bit instruction and extends it to XLEN.
module imm_format
    import imm_pkg::*;
#(
    parameter int XLEN = IMM_XLEN_32
) (
    input  logic [31:0]     instruction,
    input  logic [2:0]      imm_ctrl_ID,
    output logic [XLEN-1:0] imm,
    output logic            shamt_err
);

    logic [31:0] raw;
    logic        sign_ext;
    logic        unused_opcode;

    assign unused_opcode = ^instruction[6:0];

    // raw is already sign-extended to 32 bits for signed formats; sign_ext
    // then decides how it is widened to XLEN on RV64.
    always_comb begin
        raw       = '0;
        sign_ext  = 1'b0;
        shamt_err = 1'b0;
        case (imm_ctrl_e'(imm_ctrl_ID))
            IMM_I: begin
                raw      = {{20{instruction[31]}}, instruction[31:20]};
                sign_ext = 1'b1;
            end
            IMM_S: begin
                raw      = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
                sign_ext = 1'b1;
            end
            IMM_B: begin
                raw      = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
                sign_ext = 1'b1;
            end
            IMM_U: begin
                raw      = {instruction[31:12], 12'b0};
                sign_ext = 1'b1;
            end
            IMM_J: begin
                raw      = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
                sign_ext = 1'b1;
            end
            IMM_SHAMT: begin
                if (XLEN == IMM_XLEN_64) begin
                    raw = {26'b0, instruction[25:20]};
                end else begin
                    raw       = {27'b0, instruction[24:20]};
                    shamt_err = instruction[25];
                end
            end
            IMM_ZERO: raw = '0;
            IMM_ZIMM: raw = {27'b0, instruction[19:15]};
            default:  raw = '0;
        endcase
    end

    assign imm = sign_ext ? XLEN'($signed(raw)) : XLEN'(raw);

endmodule

// File: rtl/imm_stage.sv
// ID-stage immediate unit: formats the immediate and registers it, with its
// tag and shamt legality flag, into a 2-entry valid/ready skid buffer toward EX.
module imm_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = IMM_XLEN_32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [2:0]       imm_ctrl_ID,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_res_EX,
    output logic [TAG_W-1:0] tag_out,
    output logic             shamt_err_EX
);

    generate
        if (XLEN != IMM_XLEN_32 && XLEN != IMM_XLEN_64) begin : g_bad_xlen
            $error("imm_stage: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             shamt_err;
    } imm_entry_t;

    imm_entry_t new_entry;
    imm_entry_t m_data;
    imm_entry_t s_data;
    logic       m_valid;
    logic       s_valid;
    logic       in_fire;
    logic       out_fire;

    imm_format #(.XLEN(XLEN)) u_format (
        .instruction (instruction),
        .imm_ctrl_ID (imm_ctrl_ID),
        .imm         (new_entry.imm),
        .shamt_err   (new_entry.shamt_err)
    );

    assign new_entry.tag = tag_in;

    // in_ready depends only on the skid register, so out_ready never reaches it.
    assign in_ready = ~s_valid;
    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = m_valid & out_ready;

    // Occupancy: S is only ever filled while M is held by back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (out_fire) begin
            m_valid <= s_valid | in_fire;
            s_valid <= 1'b0;
        end else if (in_fire) begin
            if (m_valid) begin
                s_valid <= 1'b1;
            end else begin
                m_valid <= 1'b1;
            end
        end
    end

    // Payload registers only move on an accept or an S-to-M promotion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= '0;
            s_data <= '0;
        end else if (!flush) begin
            if (out_fire && s_valid) begin
                m_data <= s_data;
            end else if (in_fire && (out_fire || !m_valid)) begin
                m_data <= new_entry;
            end
            if (in_fire && m_valid && !out_fire) begin
                s_data <= new_entry;
            end
        end
    end

    assign out_valid    = m_valid;
    assign imm_res_EX   = m_data.imm;
    assign tag_out      = m_data.tag;
    assign shamt_err_EX = m_data.shamt_err;

endmodule

// File: tb/tb_imm_stage.sv
// Self-checking bench: drives an RV32 and an RV64 instance in lockstep and
// compares both against a queue-based reference of the stage.
module tb_imm_stage;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic [2:0]  imm_ctrl_ID;
    logic [31:0] tag_in;
    logic        out_ready;

    logic        in_ready32, in_ready64;
    logic        out_valid32, out_valid64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [31:0] tag32, tag64;
    logic        err32, err64;

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [31:0] tag;
        logic        err32;
        logic        err64;
    } exp_t;

    exp_t q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    imm_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready32),
        .instruction (instruction), .imm_ctrl_ID (imm_ctrl_ID), .tag_in (tag_in),
        .out_valid (out_valid32), .out_ready (out_ready),
        .imm_res_EX (imm32), .tag_out (tag32), .shamt_err_EX (err32)
    );

    imm_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk (clk), .rst (rst), .flush (flush),
        .in_valid (in_valid), .in_ready (in_ready64),
        .instruction (instruction), .imm_ctrl_ID (imm_ctrl_ID), .tag_in (tag_in),
        .out_valid (out_valid64), .out_ready (out_ready),
        .imm_res_EX (imm64), .tag_out (tag64), .shamt_err_EX (err64)
    );

    // Reference immediate: field value and field width, then two's-complement
    // sign extension done arithmetically.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] ctrl,
                                            input int xlen);
        longint v;
        int     w;
        bit     is_signed;
        v = 0;
        w = 32;
        is_signed = 1'b1;
        case (ctrl)
            3'd0: begin v = longint'(ins[31:20]); w = 12; end
            3'd1: begin v = longint'({ins[31:25], ins[11:7]}); w = 12; end
            3'd2: begin v = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); w = 13; end
            3'd3: begin v = longint'(ins[31:12]) * 4096; w = 32; end
            3'd4: begin v = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); w = 21; end
            3'd5: begin
                is_signed = 1'b0;
                v = (xlen == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
            end
            3'd6: begin is_signed = 1'b0; v = 0; end
            default: begin is_signed = 1'b0; v = longint'(ins[19:15]); end
        endcase
        if (is_signed && v >= (longint'(1) << (w - 1)))
            v = v - (longint'(1) << w);
        if (xlen == 32)
            return {32'b0, v[31:0]};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("in_ready32", {63'b0, in_ready32}, {63'b0, q.size() < 2});
        checkOutput("in_ready64", {63'b0, in_ready64}, {63'b0, q.size() < 2});
        checkOutput("out_valid32", {63'b0, out_valid32}, {63'b0, q.size() > 0});
        checkOutput("out_valid64", {63'b0, out_valid64}, {63'b0, q.size() > 0});
        if (q.size() > 0) begin
            checkOutput("imm32", {32'b0, imm32}, {32'b0, q[0].imm32});
            checkOutput("imm64", imm64, q[0].imm64);
            checkOutput("tag32", {32'b0, tag32}, {32'b0, q[0].tag});
            checkOutput("tag64", {32'b0, tag64}, {32'b0, q[0].tag});
            checkOutput("err32", {63'b0, err32}, {63'b0, q[0].err32});
            checkOutput("err64", {63'b0, err64}, {63'b0, q[0].err64});
        end
    endtask

    // Drive one cycle of inputs, advance the reference across the edge,
    // then check both instances at the following falling edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [2:0] ctrl,
                                 input logic [31:0] tag, input logic ordy, input logic fl);
        exp_t        e;
        logic [63:0] r;
        bit          in_fire, out_fire;
        in_valid    = v;
        instruction = ins;
        imm_ctrl_ID = ctrl;
        tag_in      = tag;
        out_ready   = ordy;
        flush       = fl;
        r       = ref_imm(ins, ctrl, 32);
        e.imm32 = r[31:0];
        e.imm64 = ref_imm(ins, ctrl, 64);
        e.tag   = tag;
        e.err32 = (ctrl == 3'd5) && ins[25];
        e.err64 = 1'b0;
        in_fire  = v && (q.size() < 2);
        out_fire = ordy && (q.size() > 0);
        if (fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(e);
        end
        @(negedge clk);
        checkState();
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic runDirected(input string name, input logic [31:0] ins, input logic [2:0] ctrl,
                               input logic [31:0] exp32, input logic [63:0] exp64,
                               input logic experr32, input logic experr64);
        drain();
        applyStimulus(1'b1, ins, ctrl, 32'h1234, 1'b1, 1'b0);
        checkOutput({name, "_valid"}, {63'b0, out_valid32 & out_valid64}, 64'd1);
        checkOutput({name, "_imm32"}, {32'b0, imm32}, {32'b0, exp32});
        checkOutput({name, "_imm64"}, imm64, exp64);
        checkOutput({name, "_err32"}, {63'b0, err32}, {63'b0, experr32});
        checkOutput({name, "_err64"}, {63'b0, err64}, {63'b0, experr64});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instruction = '0;
        imm_ctrl_ID = '0; tag_in = '0; out_ready = 1'b0;
        @(negedge clk);
        checkState();
        checkOutput("reset_imm64", imm64, 64'h0);
        checkOutput("reset_tag32", {32'b0, tag32}, 64'h0);
        checkOutput("reset_err32", {63'b0, err32}, 64'h0);
        rst = 1'b0;

        runDirected("i_type", 32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
        runDirected("b_type", 32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0);
        runDirected("u_type", 32'h800000B7, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b0);
        runDirected("shamt", 32'h02009093, 3'd5, 32'h0, 64'h20, 1'b1, 1'b0);
        runDirected("zimm", 32'h000FD073, 3'd7, 32'h1F, 64'h1F, 1'b0, 1'b0);
        runDirected("zero", 32'hFFFFFFFF, 3'd6, 32'h0, 64'h0, 1'b0, 1'b0);

        // Back-pressure: A held in M, B in S, C stalled until the sink drains.
        drain();
        applyStimulus(1'b1, 32'hFFF00093, 3'd0, 32'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00100093, 3'd0, 32'hB, 1'b0, 1'b0);
        checkOutput("bp_in_ready", {63'b0, in_ready32}, 64'd0);
        checkOutput("bp_head_tag", {32'b0, tag32}, 64'hA);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h00200093, 3'd0, 32'hC, 1'b0, 1'b0);
        checkOutput("bp_hold_tag", {32'b0, tag64}, 64'hA);
        applyStimulus(1'b1, 32'h00200093, 3'd0, 32'hC, 1'b1, 1'b0);
        checkOutput("bp_second_tag", {32'b0, tag32}, 64'hB);
        applyStimulus(1'b1, 32'h00200093, 3'd0, 32'hC, 1'b1, 1'b0);
        checkOutput("bp_third_tag", {32'b0, tag32}, 64'hC);
        drain();

        // Flush with both entries full and a new input offered.
        applyStimulus(1'b1, 32'h00300093, 3'd0, 32'hD1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00400093, 3'd0, 32'hD2, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00500093, 3'd0, 32'hD3, 1'b0, 1'b1);
        checkOutput("flush_out_valid", {63'b0, out_valid32}, 64'd0);
        checkOutput("flush_in_ready", {63'b0, in_ready64}, 64'd1);
        drain();

        // Asynchronous reset between edges with two entries buffered.
        applyStimulus(1'b1, 32'h00600093, 3'd0, 32'hE1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00700093, 3'd0, 32'hE2, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 q.delete();
        checkState();
        checkOutput("async_rst_valid", {63'b0, out_valid64}, 64'd0);
        checkOutput("async_rst_ready", {63'b0, in_ready32}, 64'd1);
        @(negedge clk);
        checkState();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h00800093, 3'd0, 32'hE3, 1'b1, 1'b0);
        checkOutput("post_rst_tag", {32'b0, tag32}, 64'hE3);
        drain();

        // Random traffic with random back-pressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7), $urandom, 3'($urandom_range(0, 7)),
                          $urandom, ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imm_stage.md
Name: imm_stage

Overview:
- Parametrised ID-stage immediate unit. Formats the immediate from a 32-bit RISC-V instruction, sign-extends it to XLEN (RV32 or RV64), and registers it into a 2-entry valid/ready skid buffer toward EX.
- Adds the CSR zimm format, RV64 6-bit shamt, a shamt legality flag, a pass-through tag (e.g. PC), flush, and back-pressure.
- Sits between instruction decode and the EX operand mux.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64 only, any other value is an elaboration error.
- TAG_W, 32, width of the sideband tag carried alongside the immediate.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  discard all buffered entries and the current input.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept an input this cycle.
- instruction  input  32  complete instruction word.
- imm_ctrl_ID  input  3  immediate format select.
- tag_in  input  TAG_W  sideband carried with the instruction.
- out_valid  output  1  imm_res_EX, tag_out and shamt_err_EX are valid.
- out_ready  input  1  downstream accepts this cycle.
- imm_res_EX  output  XLEN  formatted immediate.
- tag_out  output  TAG_W  tag matching imm_res_EX.
- shamt_err_EX  output  1  shift amount is illegal for this XLEN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Format encoding (imm_ctrl_ID). All results sign-extend from instruction[31] to XLEN unless stated otherwise.
  - 000 I: instruction[31:20].
  - 001 S: {instruction[31:25], instruction[11:7]}.
  - 010 B: {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 0}.
  - 011 U: {instruction[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - 100 J: {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 0}.
  - 101 SHAMT: zero-extended. XLEN=32 uses instruction[24:20]; XLEN=64 uses instruction[25:20].
  - 110 ZERO: all zeros.
  - 111 ZIMM: instruction[19:15], zero-extended.
- shamt_err: set only when imm_ctrl_ID=101, XLEN=32 and instruction[25]=1. In that case the immediate is still instruction[24:20] zero-extended.
- Handshake:
  - An input transfers when in_valid & in_ready. An output transfers when out_valid & out_ready.
  - Latency is 1 cycle from input accept to out_valid when the buffer is empty.
  - Throughput is 1 per cycle while out_ready=1.
- Storage: main register M drives the outputs; skid register S holds a second entry.
- in_ready = !S_valid, driven directly from a register with no combinational path from out_ready.
- Update rules, evaluated per rising edge:
  - Output transfers and S is valid: M <= S, S invalid.
  - Output transfers, S is empty, input accepted: M <= new entry.
  - Output transfers, S is empty, no input: M invalid.
  - No output transfer, input accepted, M is empty: M <= new entry.
  - No output transfer, input accepted, M is valid: S <= new entry, S valid.
- Ordering: in order, no loss, no duplication.
- Stability: while out_valid=1 and out_ready=0, imm_res_EX, tag_out and shamt_err_EX are held stable.
- Flush: highest priority. At the next edge M and S become invalid and the input of the flush cycle is dropped, even if in_valid & in_ready. in_ready=1 in the following cycle.
- Reset values: out_valid=0, imm_res_EX=0, tag_out=0, shamt_err_EX=0, in_ready=1, S empty.
- Reset mid-operation: all entries are lost immediately (asynchronously). No output transfer happens in the reset cycle.
- Data registers load only on accept, not every cycle.

Decomposition:
- Package imm_pkg:
  - imm_ctrl_e enum for the eight encodings above.
  - IMM_XLEN_32 and IMM_XLEN_64 constants.
  - Struct imm_entry_t holding imm, tag and shamt_err. It is width-parametrised via the module, so the package carries only the enum and constants.
- Sub-module imm_format (combinational, parameter XLEN): instruction and imm_ctrl_ID in; imm and shamt_err out.
- imm_stage instantiates imm_format plus the skid-buffer logic.

Test Plan:
- XLEN=32, I-type: instruction=0xFFF00093, ctrl=000, out_ready=1 -> one cycle later out_valid=1, imm_res_EX=0xFFFFFFFF.
- XLEN=64, B-type and U-type:
  - instruction=0xFE000EE3, ctrl=010 -> imm_res_EX=0xFFFFFFFFFFFFFFFC.
  - instruction=0x800000B7, ctrl=011 -> imm_res_EX=0xFFFFFFFF80000000.
- SHAMT with instruction=0x02009093, ctrl=101:
  - XLEN=32 -> imm_res_EX=0x0, shamt_err_EX=1.
  - XLEN=64 -> imm_res_EX=0x20, shamt_err_EX=0.
  - Also ZIMM: instruction=0x000FD073, ctrl=111 -> imm_res_EX=0x1F.
- Back-pressure: out_ready=0, send tags A, B, C on consecutive cycles -> A held in M, B in S, in_ready=0 from cycle 3 so C is stalled. Then out_ready=1 -> A, B, C emerge on consecutive cycles, outputs stable while stalled.
- Flush with M and S full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and no flushed tag ever appears at the output.
- Assert rst asynchronously between edges with two entries buffered -> out_valid=0 and in_ready=1 immediately. After release, a single input appears after 1 cycle.
